// File: rtl/melody_sequencer.sv
// Buzzer melody sequencer: walks an 8-note ROM, timing each note and gap in ticks.
// Optional `MELODY_LOOP_EN: replay from note 0 forever instead of ending in DONE.
module melody_sequencer #(
   parameter int TICK_DIV = 50000,
   parameter int GAP_MS   = 20,
   parameter int DIV_W    = 18,
   parameter int DUR_W    = 12
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iSTART,
   input  logic             iSTOP,
   output logic [DIV_W-1:0] oDIV,
   output logic             oTONE_EN,
   output logic [2:0]       oNOTE_IDX,
   output logic             oBUSY,
   output logic             oDONE
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int GW = (GAP_MS > 0) ? $clog2(GAP_MS + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_PLAY,
      S_GAP,
      S_DONE
   } state_t;

   function automatic logic [DIV_W-1:0] rom_div(input logic [2:0] i);
      logic [DIV_W-1:0] d;
      case (i)
         3'd0:    d = DIV_W'(95556);
         3'd1:    d = DIV_W'(85131);
         3'd2:    d = DIV_W'(75843);
         3'd3:    d = '0;
         3'd4:    d = DIV_W'(63776);
         3'd5:    d = DIV_W'(56818);
         3'd6:    d = DIV_W'(50619);
         default: d = DIV_W'(47778);
      endcase
      return d;
   endfunction

   function automatic logic [DUR_W-1:0] rom_dur(input logic [2:0] i);
      return (i == 3'd7) ? DUR_W'(500) : DUR_W'(250);
   endfunction

   state_t           state_q, state_d;
   logic [2:0]       idx_q, idx_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic [DUR_W-1:0] dur_q, dur_d;
   logic [GW-1:0]    gap_q, gap_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             ten_q, ten_d;
   logic [2:0]       nidx_q, nidx_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             tick;
   logic             note_end;

   assign tick = (presc_q == PW'(TICK_DIV - 1));

   // Next-state and registered-output logic for the note sequencer.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      presc_d  = presc_q;
      dur_d    = dur_q;
      gap_d    = gap_q;
      div_d    = div_q;
      ten_d    = ten_q;
      nidx_d   = nidx_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      note_end = 1'b0;

      if (iSTOP && state_q != S_IDLE) begin
         state_d = S_IDLE;
         idx_d   = '0;
         presc_d = '0;
         dur_d   = '0;
         gap_d   = '0;
         div_d   = '0;
         ten_d   = 1'b0;
         nidx_d  = '0;
         busy_d  = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               presc_d = '0;
               if (iSTART && !iSTOP) begin
                  state_d = S_LOAD;
                  idx_d   = '0;
                  busy_d  = 1'b1;
               end
            end
            S_LOAD: begin
               div_d   = rom_div(idx_q);
               ten_d   = (rom_div(idx_q) != '0);
               dur_d   = rom_dur(idx_q);
               nidx_d  = idx_q;
               presc_d = '0;
               state_d = S_PLAY;
            end
            S_PLAY: begin
               presc_d = tick ? '0 : presc_q + PW'(1);
               if (tick) begin
                  dur_d = dur_q - DUR_W'(1);
                  if (dur_q == DUR_W'(1)) begin
                     ten_d = 1'b0;
                     if (GAP_MS != 0) begin
                        state_d = S_GAP;
                        gap_d   = GW'(GAP_MS);
                        presc_d = '0;
                     end else begin
                        note_end = 1'b1;
                     end
                  end
               end
            end
            S_GAP: begin
               presc_d = tick ? '0 : presc_q + PW'(1);
               if (tick) begin
                  gap_d = gap_q - GW'(1);
                  if (gap_q == GW'(1)) begin
                     note_end = 1'b1;
                  end
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
               div_d   = '0;
               nidx_d  = '0;
               idx_d   = '0;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase

         if (note_end) begin
            presc_d = '0;
            if (idx_q == 3'd7) begin
`ifdef MELODY_LOOP_EN
               state_d = S_LOAD;
               idx_d   = '0;
`else
               state_d = S_DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
`endif
            end else begin
               state_d = S_LOAD;
               idx_d   = idx_q + 3'd1;
            end
         end
      end
   end

   // State and output registers, cleared asynchronously by iRST.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         presc_q <= '0;
         dur_q   <= '0;
         gap_q   <= '0;
         div_q   <= '0;
         ten_q   <= 1'b0;
         nidx_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         presc_q <= presc_d;
         dur_q   <= dur_d;
         gap_q   <= gap_d;
         div_q   <= div_d;
         ten_q   <= ten_d;
         nidx_q  <= nidx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign oDIV      = div_q;
   assign oTONE_EN  = ten_q;
   assign oNOTE_IDX = nidx_q;
   assign oBUSY     = busy_q;
   assign oDONE     = done_q;

endmodule
